// File: rtl/cas_tape_player.sv
// cas_tape_player: .CAS pulse-position playback engine, all timing counted in CPU ce cycles.
// Latency: ram_a/latch/eot are registered and follow the clock carrying the ce strobe; playing decodes state.
// Flow: no handshake, ce alone paces progress. Optional lead-in cells enabled by `define CAS_LEADIN_EN.
module cas_tape_player #(
  parameter int              ADDR_W    = 17,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              SYNC_LEN  = 512,
  parameter int              DATA_AT   = 1791,
  parameter int              DATA_LEN  = 512,
  parameter int              CELL_LEN  = 3593,
  parameter int              LEADIN    = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              load,
  input  logic [ADDR_W-1:0] tape_end,
  input  logic              motor,
  input  logic              poll,
  input  logic              clr,
  output logic [ADDR_W-1:0] ram_a,
  input  logic [7:0]        ram_q,
  output logic              latch,
  output logic              playing,
  output logic              eot
);

  localparam int CW = $clog2(CELL_LEN);
  localparam int LW = $clog2(LEADIN + 1);
  localparam logic [CW-1:0] SYNC_END  = CW'(SYNC_LEN);
  localparam logic [CW-1:0] DATA_POS  = CW'(DATA_AT);
  localparam logic [CW-1:0] DATA_END  = CW'(DATA_AT + DATA_LEN);
  localparam logic [CW-1:0] CELL_LAST = CW'(CELL_LEN - 1);
  localparam logic [LW-1:0] LEAD_LAST = LW'(LEADIN - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LEAD, S_PLAY, S_EOT} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [LW-1:0]     lead_cnt, lead_cnt_nxt;
  logic [2:0]        bitptr, bitptr_nxt;
  logic [ADDR_W-1:0] ram_a_nxt, ram_a_inc;
  logic              bit_val, bit_val_nxt;
  logic              end_pend, end_pend_nxt;
  logic              latch_nxt, eot_nxt;
  logic              motor_q, motor_rise, cell_wrap, set_latch, eot_entry;

  assign ram_a_inc  = ram_a + ADDR_W'(1);
  assign motor_rise = motor && !motor_q;
  assign cell_wrap  = (cnt == CELL_LAST);
  assign playing    = (state == S_PLAY) || (state == S_LEAD);

  // Next-state and datapath decode; nothing advances without ce.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lead_cnt_nxt = lead_cnt;
    bitptr_nxt   = bitptr;
    ram_a_nxt    = ram_a;
    bit_val_nxt  = bit_val;
    end_pend_nxt = end_pend;
    latch_nxt    = latch;
    eot_nxt      = eot;
    set_latch    = 1'b0;
    eot_entry    = 1'b0;
    if (ce) begin
      if (!motor) begin
        // Pointer, bit position and eot survive so the user sees where the tape stopped.
        state_nxt = S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_ARMED, S_EOT: begin
            if (motor_rise) begin
              state_nxt    = S_ARMED;
              ram_a_nxt    = BASE_ADDR;
              bitptr_nxt   = 3'd7;
              eot_nxt      = 1'b0;
              end_pend_nxt = 1'b0;
            end else if (state == S_ARMED && poll) begin
              cnt_nxt      = '0;
              lead_cnt_nxt = '0;
`ifdef CAS_LEADIN_EN
              state_nxt    = S_LEAD;
`else
              state_nxt    = S_PLAY;
`endif
            end
          end
          // Lead-in cells: sync pulse only, tape pointer untouched (unreachable without lead-in).
          S_LEAD: begin
            set_latch = (cnt < SYNC_END);
            cnt_nxt   = cell_wrap ? '0 : cnt + CW'(1);
            if (cell_wrap) begin
              if (lead_cnt == LEAD_LAST) state_nxt = S_PLAY;
              else lead_cnt_nxt = lead_cnt + LW'(1);
            end
          end
          S_PLAY: begin
            cnt_nxt = cell_wrap ? '0 : cnt + CW'(1);
            if (cnt < SYNC_END) set_latch = 1'b1;
            if (cnt == DATA_POS) begin
              bit_val_nxt = ram_q[bitptr];
              if (bitptr == 3'd0) begin
                bitptr_nxt = 3'd7;
                ram_a_nxt  = ram_a_inc;
                // Pointer ran past the last byte: finish this cell, then stop.
                if (ram_a_inc > tape_end) end_pend_nxt = 1'b1;
              end else begin
                bitptr_nxt = bitptr - 3'd1;
              end
            end
            if (cnt > DATA_POS && cnt < DATA_END && bit_val) set_latch = 1'b1;
            if (cell_wrap && end_pend) begin
              state_nxt = S_EOT;
              eot_nxt   = 1'b1;
              eot_entry = 1'b1;
            end
          end
          default: state_nxt = S_IDLE;
        endcase
      end
      // Set beats a simultaneous CPU clear; entering EOT always drops the bit.
      if (set_latch) latch_nxt = 1'b1;
      else if (clr)  latch_nxt = 1'b0;
      if (eot_entry) latch_nxt = 1'b0;
    end
  end

  // State register; reset and an active download both force a full rewind.
  always_ff @(posedge clock) begin
    if (reset || load) begin
      state    <= S_IDLE;
      cnt      <= '0;
      lead_cnt <= '0;
      bitptr   <= 3'd7;
      ram_a    <= BASE_ADDR;
      bit_val  <= 1'b0;
      end_pend <= 1'b0;
      latch    <= 1'b0;
      eot      <= 1'b0;
      motor_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lead_cnt <= lead_cnt_nxt;
      bitptr   <= bitptr_nxt;
      ram_a    <= ram_a_nxt;
      bit_val  <= bit_val_nxt;
      end_pend <= end_pend_nxt;
      latch    <= latch_nxt;
      eot      <= eot_nxt;
      if (ce) motor_q <= motor;
    end
  end

endmodule

// File: tb/tb_cas_tape_player.sv
// tb_cas_tape_player: directed bench for the cassette playback engine.
// One-byte tape (0x80) at a non-zero base; ce runs every clock except one gated stretch.
// Outputs are sampled 1 time unit after the active clock edge.
module tb_cas_tape_player;

  localparam int AW   = 17;
  localparam logic [AW-1:0] BASE = 17'h00040;
  localparam int CELL = 3593;
`ifdef CAS_LEADIN_EN
  localparam int OFS = 2 * CELL;
`else
  localparam int OFS = 0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ce    = 1'b0;
  logic          load  = 1'b0;
  logic          motor = 1'b0;
  logic          poll  = 1'b0;
  logic          clr   = 1'b0;
  logic [AW-1:0] tape_end = BASE;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_q = 8'h00;
  logic          latch, playing, eot;

  int checks = 0;
  int errors = 0;
  int nproc  = 0;

  cas_tape_player #(
    .ADDR_W(AW), .BASE_ADDR(BASE), .SYNC_LEN(512), .DATA_AT(1791),
    .DATA_LEN(512), .CELL_LEN(CELL), .LEADIN(2)
  ) dut (
    .clock(clock), .reset(reset), .ce(ce), .load(load), .tape_end(tape_end),
    .motor(motor), .poll(poll), .clr(clr), .ram_a(ram_a), .ram_q(ram_q),
    .latch(latch), .playing(playing), .eot(eot)
  );

  always #5 clock = ~clock;

  // Tape RAM: one byte 0x80 at BASE, one clock read latency.
  always @(posedge clock) ram_q <= (ram_a == BASE) ? 8'h80 : 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      tick();
      nproc++;
    end
  endtask

  // Advance until the last ce processed by the engine is data-cell index idx.
  task automatic go(input int idx);
    adv(idx + OFS + 1 - nproc);
  endtask

  task automatic clr_at(input int idx);
    go(idx - 1);
    clr = 1'b1;
    adv(1);
    clr = 1'b0;
  endtask

  task automatic start();
    poll = 1'b1;
    tick();
    poll = 1'b0;
    nproc = 0;
  endtask

  initial begin
    ce = 1'b1;
    tick();
    tick();
    chk("rst_latch", latch, 0);
    chk("rst_playing", playing, 0);
    chk("rst_eot", eot, 0);
    chk("rst_addr", ram_a, BASE);
    reset = 1'b0;
    tick();
    motor = 1'b1;
    tick();
    repeat (20) tick();
    chk("armed_latch", latch, 0);
    chk("armed_playing", playing, 0);
    start();
    chk("poll_playing", playing, 1);

`ifdef CAS_LEADIN_EN
    clr_at(1000 - OFS);
    go(1800 - OFS);
    chk("lead_no_data", latch, 0);
    chk("lead_addr", ram_a, BASE);
    go(CELL + 100 - OFS);
    chk("lead_sync2", latch, 1);
    clr_at(CELL + 1000 - OFS);
    go(-1);
    chk("lead_end_latch", latch, 0);
    chk("lead_end_addr", ram_a, BASE);
    chk("lead_playing", playing, 1);
`endif

    // Cell 0: bit 7 = 1.
    go(0);            chk("c0_sync_first", latch, 1);
    go(511);          chk("c0_sync_last", latch, 1);
    clr_at(1000);     chk("c0_clr_gap", latch, 0);
    go(1791);         chk("c0_at_sample", latch, 0);
    go(1792);         chk("c0_data_first", latch, 1);
    clr_at(2302);     chk("c0_set_wins", latch, 1);
    clr_at(2303);     chk("c0_data_over", latch, 0);
    // Cell 1: bit 6 = 0.
    clr_at(CELL + 100); chk("c1_set_wins", latch, 1);
    ce = 1'b0; clr = 1'b1;
    repeat (30) tick();
    clr = 1'b0; ce = 1'b1;
    chk("ce_gated_clr", latch, 1);
    clr_at(CELL + 1000);  chk("c1_clr", latch, 0);
    go(2 * CELL - 1);     chk("c1_zero_bit", latch, 0);
    go(2 * CELL);         chk("c2_sync", latch, 1);
    go(7 * CELL + 1790);  chk("c7_addr_hold", ram_a, BASE);
    go(7 * CELL + 1791);  chk("c7_addr_inc", ram_a, BASE + 17'd1);
    go(7 * CELL + 3591);
    chk("c7_last_playing", playing, 1);
    chk("c7_last_eot", eot, 0);
    chk("c7_last_latch", latch, 1);
    go(8 * CELL - 1);
    chk("eot_flag", eot, 1);
    chk("eot_playing", playing, 0);
    chk("eot_latch", latch, 0);
    poll = 1'b1; tick(); poll = 1'b0;
    repeat (5000) tick();
    chk("eot_hold_flag", eot, 1);
    chk("eot_hold_playing", playing, 0);
    chk("eot_hold_latch", latch, 0);
    chk("eot_hold_addr", ram_a, BASE + 17'd1);

    // Motor cycling rewinds from EOT.
    motor = 1'b0; tick();
    chk("drop_keeps_eot", eot, 1);
    motor = 1'b1; tick();
    chk("rewind_addr", ram_a, BASE);
    chk("rewind_eot", eot, 0);
    chk("rewind_playing", playing, 0);

    // Motor drop mid-tape, then re-arm.
    start();
    go(3 * CELL + 2000);
    chk("c3_latch", latch, 1);
    motor = 1'b0; tick();
    chk("drop_playing", playing, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("idle_clr", latch, 0);
    repeat (3) tick();
    motor = 1'b1; tick();
    repeat (4000) tick();
    chk("rearm_no_set", latch, 0);
    chk("rearm_playing", playing, 0);
    start();
    go(0);            chk("restart_sync", latch, 1);
    clr_at(1000);
    go(1792);         chk("restart_bit7", latch, 1);

    // Synchronous reset mid-cell.
    go(1800);
    chk("pre_reset_playing", playing, 1);
    reset = 1'b1; tick();
    chk("mid_reset_latch", latch, 0);
    chk("mid_reset_playing", playing, 0);
    chk("mid_reset_eot", eot, 0);
    chk("mid_reset_addr", ram_a, BASE);
    reset = 1'b0;

    // Download in progress forces rewind.
    tick();
    start();
    go(100);
    chk("pre_load_latch", latch, 1);
    load = 1'b1; tick();
    chk("load_latch", latch, 0);
    chk("load_playing", playing, 0);
    load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
